// File: rtl/i2c_master_pkg.sv
// i2c_master_pkg
// Shared definitions for the single-master I2C controller:
//   - default FIFO depth and command word width
//   - bit-field offsets of the command word {rw, addr[6:0], data[7:0]}
//   - FSM state encoding
package i2c_master_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CMD_W_DEF      = 16;

  localparam int CMD_RW_BIT     = 15;
  localparam int CMD_ADDR_LSB   = 8;
  localparam int CMD_ADDR_W     = 7;
  localparam int CMD_DATA_LSB   = 0;
  localparam int CMD_DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    WR_DATA,
    RD_DATA,
    ACK2,
    STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo
// Synchronous first-word-fall-through FIFO for queued I2C commands.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data when not full (dropped when full)
//   push_data   - command word
//   pop         - consume the head entry when not empty
//   pop_data    - head entry, valid whenever empty is low
//   full        - registered, high when DEPTH entries are held
//   empty       - high when no entries are held
module i2c_cmd_fifo
  import i2c_master_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = CMD_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + (PTR_W+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count - (PTR_W+1)'(1);
    end
  end

  // Pointers, count and the registered full flag. Pointers wrap naturally
  // because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == (PTR_W+1)'(DEPTH));
    end
  end

  // Storage array has no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
// Single-master I2C controller. Host strobes push {rw, addr, data} commands
// into a FIFO; the FSM runs one START/addr/ACK/byte/ACK/STOP transaction per
// command. One bus bit lasts one system clock: SCL low while the clock is
// high, SCL high while the clock is low.
// Ports:
//   i2c_clock_in        - system clock (one bit period)
//   i2c_reset_in        - asynchronous active-low reset
//   i2c_start           - one-cycle push strobe
//   rw_bit              - 0 write, 1 read
//   i2c_master_addr_wr  - 7-bit slave address
//   i2c_master_data_wr  - byte to write
//   i2c_master_data_rd  - last byte read from a slave
//   fifo_full           - command FIFO is full
//   ready_out           - FSM idle
//   i2c_sda_inout       - open-drain SDA (0 or Z)
//   i2c_scl_inout       - open-drain SCL (0 or Z)
module i2c_master_ctrl
  import i2c_master_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CMD_W      = CMD_W_DEF
) (
  input  logic       i2c_clock_in,
  input  logic       i2c_reset_in,
  input  logic       i2c_start,
  input  logic       rw_bit,
  input  logic [6:0] i2c_master_addr_wr,
  input  logic [7:0] i2c_master_data_wr,
  output logic [7:0] i2c_master_data_rd,
  output logic       fifo_full,
  output logic       ready_out,
  inout  wire        i2c_sda_inout,
  inout  wire        i2c_scl_inout
);

  i2c_state_e        state;
  i2c_state_e        state_next;
  logic [CMD_W-1:0]  cmd_reg;
  logic [CMD_W-1:0]  fifo_data;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_cnt;
  logic              scl_en;
  logic              scl_en_next;
  logic              sda_sample;
  logic              sda_pull_low;
  logic              cmd_rw;
  logic [6:0]        cmd_addr;
  logic [7:0]        cmd_data;

  assign cmd_rw   = cmd_reg[CMD_RW_BIT];
  assign cmd_addr = cmd_reg[CMD_ADDR_LSB +: CMD_ADDR_W];
  assign cmd_data = cmd_reg[CMD_DATA_LSB +: CMD_DATA_W];

  i2c_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (i2c_clock_in),
    .rst_n     (i2c_reset_in),
    .push      (i2c_start),
    .push_data ({rw_bit, i2c_master_addr_wr, i2c_master_data_wr}),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic. The SCL enable covers only the clocked bit states;
  // START and STOP keep SCL high so the SDA edges there form proper
  // start/stop conditions.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = START;
        end
      end
      START:   state_next = ADDR;
      ADDR:    if (bit_cnt == 3'd7) state_next = ACK1;
      ACK1: begin
        if (sda_sample)  state_next = STOP;
        else if (cmd_rw) state_next = RD_DATA;
        else             state_next = WR_DATA;
      end
      WR_DATA: if (bit_cnt == 3'd7) state_next = ACK2;
      RD_DATA: if (bit_cnt == 3'd7) state_next = ACK2;
      ACK2:    state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    scl_en_next = (state_next == ADDR)    || (state_next == ACK1) ||
                  (state_next == WR_DATA) || (state_next == RD_DATA) ||
                  (state_next == ACK2);
  end

  // State register plus datapath: command capture on pop, shift register
  // for address/data bits, bit counter and the read-data latch.
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_in) begin
    if (!i2c_reset_in) begin
      state              <= IDLE;
      scl_en             <= 1'b0;
      cmd_reg            <= '0;
      shift_reg          <= '0;
      bit_cnt            <= '0;
      i2c_master_data_rd <= '0;
    end else begin
      state  <= state_next;
      scl_en <= scl_en_next;
      case (state)
        IDLE: begin
          if (!fifo_empty) cmd_reg <= fifo_data;
        end
        START: begin
          shift_reg <= {cmd_addr, cmd_rw};
          bit_cnt   <= '0;
        end
        ADDR, WR_DATA: begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        ACK1: begin
          shift_reg <= cmd_data;
          bit_cnt   <= '0;
        end
        RD_DATA: begin
          shift_reg <= {shift_reg[6:0], sda_sample};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) i2c_master_data_rd <= {shift_reg[6:0], sda_sample};
        end
        default: begin
        end
      endcase
    end
  end

  // SDA is sampled at the SCL rising edge (clock falling edge); the FSM
  // consumes the sample on the following rising clock edge.
  always_ff @(negedge i2c_clock_in or negedge i2c_reset_in) begin
    if (!i2c_reset_in) sda_sample <= 1'b1;
    else               sda_sample <= i2c_sda_inout;
  end

  // SDA pull-down decode. Data bits change only with state/shift updates at
  // the rising clock edge. In STOP, SDA is held low for the first half of
  // the cycle and released mid-cycle while SCL stays high.
  always_comb begin
    sda_pull_low = 1'b0;
    case (state)
      START:         sda_pull_low = 1'b1;
      ADDR, WR_DATA: sda_pull_low = ~shift_reg[7];
      STOP:          sda_pull_low = i2c_clock_in;
      default:       sda_pull_low = 1'b0;
    endcase
  end

  assign i2c_sda_inout = sda_pull_low ? 1'b0 : 1'bz;
  assign i2c_scl_inout = (scl_en & i2c_clock_in) ? 1'b0 : 1'bz;
  assign ready_out     = (state == IDLE);

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl
// Directed bench for i2c_master_ctrl: a vector table of single transactions
// with a cycle-scheduled slave, plus hand-written sequences for reset,
// FIFO overflow and reset in the middle of a transaction.
module tb_i2c_master_ctrl;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       slave_ack;
    logic [7:0] slave_rd;
    logic [7:0] exp_addr_byte;
    logic [7:0] exp_wire_data;
    int         exp_len;
    logic [7:0] exp_data_rd;
    logic       exp_ack2_bus;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       rw;
  logic [6:0] addr_wr;
  logic [7:0] data_wr;
  logic [7:0] data_rd;
  logic       full;
  logic       ready;
  wire        sda_w;
  wire        scl_w;
  logic       slv_low_tbl;
  logic       slv_low_mon;

  int         num_checks;
  int         num_passed;

  logic       mon_en;
  int         mon_pos;
  logic [7:0] mon_shift;
  logic [7:0] mon_addrs[$];
  logic       m_fh_scl;
  logic       m_fh_sda;

  vec_t       vecs[6];

  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = (slv_low_tbl | slv_low_mon) ? 1'b0 : 1'bz;

  i2c_master_ctrl dut (
    .i2c_clock_in       (clk),
    .i2c_reset_in       (rst_n),
    .i2c_start          (start),
    .rw_bit             (rw),
    .i2c_master_addr_wr (addr_wr),
    .i2c_master_data_wr (data_wr),
    .i2c_master_data_rd (data_rd),
    .fifo_full          (full),
    .ready_out          (ready),
    .i2c_sda_inout      (sda_w),
    .i2c_scl_inout      (scl_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual == expected) num_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Push one command and walk 25 bus cycles, acting as the slave on a fixed
  // schedule: cycle 1 START, 2-9 address, 10 ACK1, then either 11 STOP (NACK)
  // or 11-18 data, 19 ACK2, 20 STOP.
  task automatic applyStimulus(input int vid, input vec_t v);
    logic [7:0] addr_byte;
    logic [7:0] wire_byte;
    logic [7:0] rd_shift;
    logic       fh_scl, fh_sda, sh_scl, sh_sda;
    logic       start_ok, stop_ok, ack2_bus;
    int         busy, viol;
    addr_byte = '0; wire_byte = '0; rd_shift = v.slave_rd;
    start_ok = 1'b0; stop_ok = 1'b0; ack2_bus = 1'b0;
    busy = 0; viol = 0;
    @(negedge clk);
    rw = v.rw; addr_wr = v.addr; data_wr = v.wdata; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      slv_low_tbl = 1'b0;
      if (v.slave_ack) begin
        if (k == 10) slv_low_tbl = 1'b1;
        else if (v.rw && k >= 11 && k <= 18) begin
          slv_low_tbl = ~rd_shift[7];
          rd_shift    = {rd_shift[6:0], 1'b0};
        end else if (!v.rw && k == 19) slv_low_tbl = 1'b1;
      end
      #1;
      fh_scl = scl_w; fh_sda = sda_w;
      @(negedge clk);
      #1;
      sh_scl = scl_w; sh_sda = sda_w;
      if (!ready) busy++;
      if (k >= 2 && k <= 9)   addr_byte = {addr_byte[6:0], sh_sda};
      if (k >= 11 && k <= 18) wire_byte = {wire_byte[6:0], sh_sda};
      if (k == 1) start_ok = fh_scl & ~fh_sda & sh_scl & ~sh_sda;
      if (k == v.exp_len) stop_ok = fh_scl & ~fh_sda & sh_scl & sh_sda;
      if (k >= 2 && k < v.exp_len && !(!fh_scl && sh_scl)) viol++;
      if (k == 19) ack2_bus = sh_sda;
    end
    slv_low_tbl = 1'b0;
    checkOutput($sformatf("v%0d_addr_byte", vid), 32'(addr_byte), 32'(v.exp_addr_byte));
    if (!v.rw && v.slave_ack)
      checkOutput($sformatf("v%0d_wr_data_byte", vid), 32'(wire_byte), 32'(v.exp_wire_data));
    checkOutput($sformatf("v%0d_start_cond", vid), 32'(start_ok), 32'd1);
    checkOutput($sformatf("v%0d_scl_clock_errors", vid), 32'(viol), 32'd0);
    checkOutput($sformatf("v%0d_stop_cond", vid), 32'(stop_ok), 32'd1);
    checkOutput($sformatf("v%0d_busy_cycles", vid), 32'(busy), 32'(v.exp_len));
    checkOutput($sformatf("v%0d_data_rd", vid), 32'(data_rd), 32'(v.exp_data_rd));
    if (v.slave_ack)
      checkOutput($sformatf("v%0d_ack2_bus", vid), 32'(ack2_bus), 32'(v.exp_ack2_bus));
  endtask

  // Passive decoder that also ACKs writes: finds a START cycle (SCL high and
  // SDA low in both halves), collects the address byte, and pulls SDA low in
  // the ACK1 and ACK2 slots of a 20-cycle write.
  initial begin
    mon_pos = -1;
    mon_shift = '0;
    slv_low_mon = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      slv_low_mon = mon_en && (mon_pos == 9 || mon_pos == 18);
      #1;
      m_fh_scl = scl_w; m_fh_sda = sda_w;
      @(negedge clk);
      #1;
      if (!mon_en) mon_pos = -1;
      else if (mon_pos < 0) begin
        if (m_fh_scl && !m_fh_sda && scl_w && !sda_w) mon_pos = 1;
      end else begin
        if (mon_pos <= 8) mon_shift = {mon_shift[6:0], sda_w};
        if (mon_pos == 8) mon_addrs.push_back(mon_shift);
        mon_pos++;
        if (mon_pos >= 20) mon_pos = -1;
      end
    end
  end

  initial begin
    int low_cnt;
    int nready_cnt;
    int waited;
    num_checks = 0; num_passed = 0;
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr_wr = '0; data_wr = '0;
    slv_low_tbl = 1'b0; mon_en = 1'b0;

    vecs[0] = '{1'b0, 7'h55, 8'hD3, 1'b1, 8'h00, 8'hAA, 8'hD3, 20, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 7'h59, 8'h00, 1'b1, 8'h99, 8'hB3, 8'h00, 20, 8'h99, 1'b1};
    vecs[2] = '{1'b0, 7'h12, 8'h34, 1'b0, 8'h00, 8'h24, 8'h00, 11, 8'h99, 1'b0};
    vecs[3] = '{1'b1, 7'h7F, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 11, 8'h99, 1'b0};
    vecs[4] = '{1'b1, 7'h01, 8'h00, 1'b1, 8'h5A, 8'h03, 8'h00, 20, 8'h5A, 1'b1};
    vecs[5] = '{1'b0, 7'h40, 8'h81, 1'b1, 8'h00, 8'h80, 8'h81, 20, 8'h5A, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_data_rd", 32'(data_rd), 32'h00);
    checkOutput("rst_fifo_full", 32'(full), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_sda", 32'(sda_w), 32'd1);
    checkOutput("rst_scl", 32'(scl_w), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_rst_ready", 32'(ready), 32'd1);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // Reset in the middle of the address phase with a second command queued
    @(negedge clk);
    rw = 1'b0; addr_wr = 7'h00; data_wr = 8'h00; start = 1'b1;
    @(negedge clk);
    addr_wr = 7'h00; data_wr = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_rst_scl_low", 32'(scl_w), 32'd0);
    checkOutput("pre_rst_sda_low", 32'(sda_w), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_scl", 32'(scl_w), 32'd1);
    checkOutput("mid_rst_sda", 32'(sda_w), 32'd1);
    checkOutput("mid_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0; nready_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (!sda_w) low_cnt++;
      if (!ready) nready_cnt++;
    end
    checkOutput("mid_rst_no_txn_sda", 32'(low_cnt), 32'd0);
    checkOutput("mid_rst_no_txn_ready", 32'(nready_cnt), 32'd0);

    // FIFO overflow: one command starts the FSM, then 9 strobes while busy
    mon_en = 1'b1;
    @(negedge clk);
    rw = 1'b0; addr_wr = 7'h0F; data_wr = 8'hA0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i == 7) checkOutput("fifo_full_after_7", 32'(full), 32'd0);
      if (i == 8) checkOutput("fifo_full_after_8", 32'(full), 32'd1);
      addr_wr = 7'(8'h10 + i); data_wr = 8'(i); start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("fifo_full_after_9", 32'(full), 32'd1);
    waited = 0;
    while (waited < 400 && !(mon_addrs.size() >= 9 && ready)) begin
      @(negedge clk);
      waited++;
    end
    repeat (40) @(negedge clk);
    checkOutput("fifo_txn_count", 32'(mon_addrs.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] got;
      logic [7:0] exp_byte;
      exp_byte = (i == 0) ? 8'h1E : 8'((8'h10 + i - 1) << 1);
      got = (i < mon_addrs.size()) ? mon_addrs[i] : 8'h00;
      checkOutput($sformatf("fifo_txn%0d_addr", i), 32'(got), 32'(exp_byte));
    end
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
